date_setter: RTL and testbench

DATE_SETTER -- requirements
Module: date_setter

---
 rtl/date_setter.sv | 195 +++++++++++++++++++
 tb/tb_date_setter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/date_setter.sv
// date_setter: push-button date/time editor for six external counters.
// A session walks year, month, day, hour, minute and second in turn:
// each field is read from its counter, edited in a shadow register and
// written back with a one-cycle load strobe.
// Optional feature: define LEAP_YEAR_EN to give February 29 days in years
// whose two low bits are zero; without it February always has 28 days.
module date_setter (
    input  logic       clk,
    input  logic       clear,
    input  logic       btn_set,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [5:0] databus,
    output logic [5:0] en,
    output logic [5:0] ld,
    output logic [5:0] data,
    output logic [2:0] field,
    output logic       editing
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EDIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] field_nxt;
    logic [5:0] shadow;
    logic [5:0] shadow_nxt;
    logic [3:0] month_q;
    logic [3:0] month_nxt;

    // Button order in the vectors below: bit 0 set, bit 1 mode, bit 2 inc
    logic [2:0] btn_raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] prev;
    logic [2:0] pulse;

    logic       set_p;
    logic       mode_p;
    logic       inc_p;

    logic [5:0] fmin;
    logic [5:0] fmax;
    logic [5:0] dmax;
    logic [5:0] feb_days;

    assign btn_raw = {btn_inc, btn_mode, btn_set};

    // Two-flop synchronizer followed by a rising-edge detector per button
    always_ff @(posedge clk) begin
        if (clear) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
            prev  <= 3'b000;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse  = sync2 & ~prev;
    assign set_p  = pulse[0];
    assign mode_p = pulse[1];
    assign inc_p  = pulse[2];

`ifdef LEAP_YEAR_EN
    // Only the two low bits of the year matter for the leap rule
    logic [1:0] year_q;
    logic [1:0] year_nxt;

    // Stored year, captured when the year field is written
    always_ff @(posedge clk) begin
        if (clear)
            year_q <= 2'd0;
        else
            year_q <= year_nxt;
    end

    // Year write-back happens only in WRITE for field 0
    always_comb begin
        year_nxt = year_q;
        if (state == WRITE && field == 3'd0)
            year_nxt = shadow[1:0];
    end

    assign feb_days = (year_q == 2'd0) ? 6'd29 : 6'd28;
`else
    assign feb_days = 6'd28;
`endif

    // Legal range of the field currently being edited
    always_comb begin
        dmax = 6'd31;
        case (month_q)
            4'd4, 4'd6, 4'd9, 4'd11: dmax = 6'd30;
            4'd2:                    dmax = feb_days;
            default:                 dmax = 6'd31;
        endcase
        fmin = 6'd0;
        fmax = 6'd59;
        case (field)
            3'd1:    begin fmin = 6'd1; fmax = 6'd12; end
            3'd2:    begin fmin = 6'd1; fmax = dmax;  end
            3'd3:    begin fmin = 6'd0; fmax = 6'd23; end
            default: begin fmin = 6'd0; fmax = 6'd59; end
        endcase
    end

    // State, field index, shadow value and stored month registers
    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= IDLE;
            field   <= 3'd0;
            shadow  <= 6'd0;
            month_q <= 4'd1;
        end else begin
            state   <= state_nxt;
            field   <= field_nxt;
            shadow  <= shadow_nxt;
            month_q <= month_nxt;
        end
    end

    // Next-state logic; set outranks mode, mode outranks inc in EDIT
    always_comb begin
        state_nxt  = state;
        field_nxt  = field;
        shadow_nxt = shadow;
        month_nxt  = month_q;
        case (state)
            IDLE: begin
                if (set_p) begin
                    state_nxt = FETCH;
                    field_nxt = 3'd0;
                end
            end
            FETCH: begin
                if (databus < fmin || databus > fmax)
                    shadow_nxt = fmin;
                else
                    shadow_nxt = databus;
                state_nxt = EDIT;
            end
            EDIT: begin
                if (set_p) begin
                    state_nxt = IDLE;
                    field_nxt = 3'd0;
                end else if (mode_p) begin
                    state_nxt = WRITE;
                end else if (inc_p) begin
                    if (shadow >= fmax)
                        shadow_nxt = fmin;
                    else
                        shadow_nxt = shadow + 6'd1;
                end
            end
            WRITE: begin
                if (field == 3'd1)
                    month_nxt = shadow[3:0];
                if (field == 3'd5) begin
                    state_nxt = IDLE;
                    field_nxt = 3'd0;
                end else begin
                    state_nxt = FETCH;
                    field_nxt = field + 3'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                field_nxt = 3'd0;
            end
        endcase
    end

    // Counter strobes decoded from the registered state and field index
    always_comb begin
        en      = 6'd0;
        ld      = 6'd0;
        data    = 6'd0;
        editing = (state != IDLE);
        if (state == FETCH)
            en = 6'b000001 << field;
        if (state == WRITE) begin
            ld   = 6'b000001 << field;
            data = shadow;
        end
    end

endmodule

// File: tb/tb_date_setter.sv
// tb_date_setter: self-checking bench for date_setter. A calendar model
// computes the value each field write must carry from the value on the
// bus, the number of increments and the month/year written earlier.
module tb_date_setter;

    logic       clk;
    logic       clear;
    logic       btn_set;
    logic       btn_mode;
    logic       btn_inc;
    logic [5:0] databus;
    logic [5:0] en;
    logic [5:0] ld;
    logic [5:0] data;
    logic [2:0] field;
    logic       editing;

    int checks;
    int failures;
    int modelYear;
    int modelMonth;
    int busVal[6];
    int incCount[6];
    int lastData[6];

    date_setter dut (
        .clk     (clk),
        .clear   (clear),
        .btn_set (btn_set),
        .btn_mode(btn_mode),
        .btn_inc (btn_inc),
        .databus (databus),
        .en      (en),
        .ld      (ld),
        .data    (data),
        .field   (field),
        .editing (editing)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against the run never finishing
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press the given buttons from a falling edge; returns at the falling
    // edge right after the cycle in which the press takes effect
    task automatic applyStimulus(input logic s, input logic m, input logic i);
        btn_set  = s;
        btn_mode = m;
        btn_inc  = i;
        repeat (3) @(posedge clk);
        @(negedge clk);
        btn_set  = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    function automatic int dayMax();
        if (modelMonth == 4 || modelMonth == 6 || modelMonth == 9 || modelMonth == 11)
            return 30;
        if (modelMonth == 2) begin
`ifdef LEAP_YEAR_EN
            return (modelYear % 4 == 0) ? 29 : 28;
`else
            return 28;
`endif
        end
        return 31;
    endfunction

    function automatic int fieldMin(input int f);
        return (f == 1 || f == 2) ? 1 : 0;
    endfunction

    function automatic int fieldMax(input int f);
        case (f)
            1:       return 12;
            2:       return dayMax();
            3:       return 23;
            default: return 59;
        endcase
    endfunction

    // Value written for field f: clamp the bus value, then count modulo range
    function automatic int expectedWrite(input int f, input int bus, input int incs);
        int lo;
        int hi;
        int v;
        lo = fieldMin(f);
        hi = fieldMax(f);
        v  = (bus < lo || bus > hi) ? lo : bus;
        return lo + ((v - lo + incs) % (hi - lo + 1));
    endfunction

    // One complete edit session over all six fields using busVal/incCount
    task automatic runSession();
        int exp;
        databus = busVal[0][5:0];
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("fetch_en0", int'(en), 1);
        checkOutput("fetch_editing", int'(editing), 1);
        for (int f = 0; f < 6; f++) begin
            waitCycles(2);
            checkOutput("edit_quiet", int'({en, ld}), 0);
            for (int k = 0; k < incCount[f]; k++) begin
                applyStimulus(1'b0, 1'b0, 1'b1);
                waitCycles(3);
            end
            applyStimulus(1'b0, 1'b1, 1'b0);
            exp = expectedWrite(f, busVal[f], incCount[f]);
            checkOutput("write_ld", int'(ld), 1 << f);
            checkOutput("write_data", int'(data), exp);
            checkOutput("write_field", int'(field), f);
            checkOutput("write_en", int'(en), 0);
            lastData[f] = int'(data);
            if (f == 0) modelYear = exp;
            if (f == 1) modelMonth = exp;
            if (f < 5) begin
                databus = busVal[f + 1][5:0];
                waitCycles(1);
                checkOutput("fetch_en", int'(en), 1 << (f + 1));
                checkOutput("fetch_ld", int'(ld), 0);
            end else begin
                waitCycles(1);
                checkOutput("done_editing", int'(editing), 0);
                checkOutput("done_ld", int'(ld), 0);
                checkOutput("done_field", int'(field), 0);
                waitCycles(2);
            end
        end
    endtask

    task automatic setSession(input int y, input int mo, input int d,
                              input int h, input int mi, input int s);
        busVal[0] = y;  busVal[1] = mo; busVal[2] = d;
        busVal[3] = h;  busVal[4] = mi; busVal[5] = s;
        for (int k = 0; k < 6; k++) incCount[k] = 0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        modelYear  = 0;
        modelMonth = 1;
        clear      = 1'b1;
        btn_set    = 1'b0;
        btn_mode   = 1'b0;
        btn_inc    = 1'b0;
        databus    = 6'd0;
        waitCycles(3);
        clear = 1'b0;
        waitCycles(1);

        // Reset state
        checkOutput("rst_en", int'(en), 0);
        checkOutput("rst_ld", int'(ld), 0);
        checkOutput("rst_data", int'(data), 0);
        checkOutput("rst_field", int'(field), 0);
        checkOutput("rst_editing", int'(editing), 0);

        // mode/inc in IDLE are ignored
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("idle_ignore", int'(editing), 0);
        waitCycles(3);

        // Full pass with no increments, year 0x17
        setSession(23, 5, 10, 12, 30, 45);
        runSession();
        checkOutput("year_23", lastData[0], 23);

        // Hour wraps from 23 to 0
        setSession(23, 7, 15, 23, 0, 0);
        incCount[3] = 1;
        runSession();
        checkOutput("hour_wrap", lastData[3], 0);

        // February: day 31 clamps, 28 increments
        setSession(24, 2, 31, 1, 2, 3);
        incCount[2] = 28;
        runSession();
`ifdef LEAP_YEAR_EN
        checkOutput("feb_day", lastData[2], 29);
`else
        checkOutput("feb_day", lastData[2], 1);
`endif

        // Abort with set and mode together: set wins, no load
        databus = 6'd10;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("abort_editing", int'(editing), 0);
        checkOutput("abort_field", int'(field), 0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("abort_ld", int'(ld), 0);
            waitCycles(1);
        end

        // inc and mode together: write of the unincremented value
        databus = 6'd37;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(3);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("prio_ld", int'(ld), 1);
        checkOutput("prio_data", int'(data), expectedWrite(0, 37, 0));
        modelYear = 37;
        waitCycles(3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("prio_abort", int'(editing), 0);
        waitCycles(3);

        // Clear on the edge that would enter WRITE
        databus = 6'd40;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(3);
        btn_mode = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear    = 1'b0;
        btn_mode = 1'b0;
        checkOutput("clr_ld", int'(ld), 0);
        checkOutput("clr_en", int'(en), 0);
        checkOutput("clr_data", int'(data), 0);
        checkOutput("clr_field", int'(field), 0);
        checkOutput("clr_editing", int'(editing), 0);
        waitCycles(1);
        checkOutput("clr_ld_after", int'(ld), 0);
        modelYear  = 0;
        modelMonth = 1;
        waitCycles(3);

        // Randomized sessions, bus values may be out of range
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 6; k++) begin
                busVal[k]   = int'($urandom_range(0, 63));
                incCount[k] = int'($urandom_range(0, 3));
            end
            if (r == 2) busVal[1] = 2;
            if (r == 3) begin busVal[0] = 4 * int'($urandom_range(0, 14)); busVal[1] = 2; end
            runSession();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
